pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of decode-flush cycles after a redirect (legal 1..3).
REQ-002 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port de_rs1, de_rs2  input  5 each  source registers of the instruction at decode input.
REQ-006 SHALL have port de_use_rs1, de_use_rs2  input  1 each  instruction at decode reads that source.
REQ-007 SHALL have port ex_rd  input  5  destination of the instruction latched decode->execute.
REQ-008 SHALL have port ex_mem_read, ex_valid  input  1 each  that instruction is a load / is valid (v_de).
REQ-009 SHALL have port redirect  input  1  one-cycle pulse from execute: taken branch or jump, PC reloads target.
REQ-010 SHALL have port mem_busy  input  1  data memory not ready; whole pipeline freezes.
REQ-011 SHALL have port halt_req, resume  input  1 each  debug halt request / release.
REQ-012 SHALL have port pc_en, fe_en, de_en, ex_en  output  1 each  stage register enables (de_en drives decode en).
REQ-013 SHALL have port de_flush  output  1  drives decode pc_r; captured decode->execute entry becomes invalid.
REQ-014 SHALL have port halted  output  1  controller is in HALT.
REQ-015 SHALL have ports stall_cnt and flush_cnt  output  CNT_W each  saturating performance counters.

Function
REQ-016 SHALL implement states INIT, RUN, FLUSH, HALT.
REQ-017 INIT SHALL drive all enables 1, de_flush 1, and go to RUN after exactly one cycle.
REQ-018 Load-use hazard SHALL be ex_valid & ex_mem_read & ex_rd!=0 & ((de_use_rs1 & de_rs1==ex_rd) | (de_use_rs2 & de_rs2==ex_rd)), combinational.
REQ-019 In RUN with hazard: pc_en=0, fe_en=0, de_en=1, de_flush=1, ex_en=1 in the same cycle, inserting one bubble while fetch holds; the state stays RUN.
REQ-020 In RUN without hazard: all enables 1, de_flush 0.
REQ-021 On redirect in RUN or FLUSH: go to FLUSH, load the counter with FLUSH_CYCLES-1, and drive de_flush=1 with all enables 1 in the redirect cycle itself.
REQ-022 In FLUSH: de_flush=1, all enables 1, hazard ignored; count down and return to RUN after the cycle the counter is 0.
REQ-023 A redirect during FLUSH SHALL restart the count.
REQ-024 Priority SHALL be: mem_busy > redirect > hazard > halt_req.
REQ-025 While mem_busy=1: all enables 0, de_flush 0, state and flush counter held; a redirect in that cycle is ignored, because execute holds it.
REQ-026 halt_req SHALL be sampled only in RUN with no redirect or hazard; it enters HALT next cycle, and the halt_req cycle itself is a normal RUN cycle.
REQ-027 HALT: all enables 0, de_flush 0, halted=1; on resume, go to RUN next cycle; halt_req and resume both high in HALT means leave.
REQ-028 stall_cnt SHALL add 1 each cycle pc_en=0 outside INIT and HALT; it saturates at all-ones.
REQ-029 flush_cnt SHALL add 1 per accepted redirect; it saturates at all-ones.

Reset
REQ-030 reset_n low SHALL asynchronously force state INIT, flush counter 0, stall_cnt 0, flush_cnt 0.
REQ-031 During reset, outputs SHALL be pc_en/fe_en/de_en/ex_en=0, de_flush=1, halted=0.
REQ-032 Reset asserted mid-FLUSH or mid-HALT SHALL abandon that state with no residual effect.

Structure
REQ-033 pipe_ctrl_state_e SHALL live in the shared riscv_structures package.
REQ-034 Load-use comparison SHALL be sub-module hazard_detect, purely combinational, reusable for future forwarding.
REQ-035 No other sub-modules; the counters are inline.

Verification
REQ-036 Load-use: ex = valid lw x5, decode = add x6,x5,x7 -> one cycle pc_en=0, de_flush=1; next cycle all enables 1; stall_cnt=1.
REQ-037 No false hazard: ex_rd=0 with load, or ex_valid=0, or de_use_rs2=0 with rs2 match -> no stall.
REQ-038 Redirect: pulse at cycle N with FLUSH_CYCLES=2 -> de_flush high in N and N+1, RUN at N+2, flush_cnt=1; a second pulse at N+1 extends de_flush to N+2.
REQ-039 mem_busy for 3 cycles during FLUSH -> enables 0, flush resumes with the same remaining count, stall_cnt +3.
REQ-040 Halt: halt_req in RUN -> halted=1 next cycle, enables 0; resume -> RUN next cycle; reset_n low mid-HALT -> INIT outputs immediately.
REQ-041 Saturation: force 2^CNT_W redirects -> flush_cnt holds all-ones, no wrap.

Source files
------------

// File: rtl/riscv_structures.sv
// Shared RISC-V core types: pipeline-control FSM state and register-file constants.
package riscv_structures;

  typedef enum logic [1:0] {
    PC_INIT  = 2'd0,
    PC_RUN   = 2'd1,
    PC_FLUSH = 2'd2,
    PC_HALT  = 2'd3
  } pipe_ctrl_state_e;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator between decode sources and the execute-stage load.
// Per-source match outputs are exposed so a forwarding unit can reuse them.
module hazard_detect
  import riscv_structures::*;
(
  input  logic [REG_ADDR_W-1:0] de_rs1,
  input  logic [REG_ADDR_W-1:0] de_rs2,
  input  logic                  de_use_rs1,
  input  logic                  de_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_valid,
  output logic                  rs1_match,
  output logic                  rs2_match,
  output logic                  load_use
);

  // x0 is hardwired zero, so a write to it never creates a dependency.
  logic ex_writes;

  assign ex_writes = ex_valid && (ex_rd != REG_ZERO);
  assign rs1_match = ex_writes && de_use_rs1 && (de_rs1 == ex_rd);
  assign rs2_match = ex_writes && de_use_rs2 && (de_rs2 == ex_rd);
  assign load_use  = ex_mem_read && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stage enables, decode flush after redirects, load-use
// bubbles, memory-wait freeze, debug halt and saturating performance counters.
module pipeline_ctrl
  import riscv_structures::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] de_rs1,
  input  logic [REG_ADDR_W-1:0] de_rs2,
  input  logic                  de_use_rs1,
  input  logic                  de_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_valid,
  input  logic                  redirect,
  input  logic                  mem_busy,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic                  pc_en,
  output logic                  fe_en,
  output logic                  de_en,
  output logic                  ex_en,
  output logic                  de_flush,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // The redirect cycle is itself the first flush cycle, so the counter holds
  // the number of extra FLUSH-state cycles still owed.
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  pipe_ctrl_state_e state, state_next;
  logic [1:0]       fcnt, fcnt_next;
  logic             hazard, rs1_match, rs2_match;
  logic             redirect_acc;
  logic             stall_inc;

  hazard_detect u_hazard_detect (
    .de_rs1      (de_rs1),
    .de_rs2      (de_rs2),
    .de_use_rs1  (de_use_rs1),
    .de_use_rs2  (de_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_valid    (ex_valid),
    .rs1_match   (rs1_match),
    .rs2_match   (rs2_match),
    .load_use    (hazard)
  );

  // NOTE: every output of this block is given a default first so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next   = state;
    fcnt_next    = fcnt;
    redirect_acc = 1'b0;
    pc_en        = 1'b0;
    fe_en        = 1'b0;
    de_en        = 1'b0;
    ex_en        = 1'b0;
    de_flush     = 1'b0;

    if (!reset_n) begin
      de_flush = 1'b1;
    end else if (state == PC_INIT) begin
      {pc_en, fe_en, de_en, ex_en} = 4'b1111;
      de_flush   = 1'b1;
      state_next = PC_RUN;
    end else if (!mem_busy) begin
      // A busy memory falls through with everything frozen; execute keeps any
      // pending redirect and presents it again once the memory is ready.
      unique case (state)
        PC_RUN: begin
          {pc_en, fe_en, de_en, ex_en} = 4'b1111;
          if (redirect) begin
            redirect_acc = 1'b1;
            de_flush     = 1'b1;
            fcnt_next    = FLUSH_LOAD;
            state_next   = (FLUSH_LOAD == 2'd0) ? PC_RUN : PC_FLUSH;
          end else if (hazard) begin
            pc_en    = 1'b0;
            fe_en    = 1'b0;
            de_flush = 1'b1;
          end else if (halt_req) begin
            state_next = PC_HALT;
          end
        end
        PC_FLUSH: begin
          {pc_en, fe_en, de_en, ex_en} = 4'b1111;
          de_flush = 1'b1;
          if (redirect) begin
            redirect_acc = 1'b1;
            fcnt_next    = FLUSH_LOAD;
            state_next   = (FLUSH_LOAD == 2'd0) ? PC_RUN : PC_FLUSH;
          end else begin
            fcnt_next  = fcnt - 2'd1;
            state_next = (fcnt <= 2'd1) ? PC_RUN : PC_FLUSH;
          end
        end
        PC_HALT: begin
          if (resume) state_next = PC_RUN;
        end
        default: state_next = PC_INIT;
      endcase
    end
  end

  assign halted    = (state == PC_HALT);
  assign stall_inc = !pc_en && ((state == PC_RUN) || (state == PC_FLUSH));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PC_INIT;
      fcnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_next;
      fcnt  <= fcnt_next;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_acc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
